mips_cpu_harvard: RTL and testbench
===================================

MIPS_CPU_HARVARD -- requirements
Module: mips_cpu_harvard

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 active  output  1  high while CPU is running, low once halted.
REQ-004 register_v0  output  32  live value of GPR $2 (v0).
REQ-005 clk_enable  input  1  stall qualifier; used only as defined under Configuration.
REQ-006 instr_address  output  32  byte address of current instruction (= PC).
REQ-007 instr_readdata  input  32  instruction word at instr_address, valid combinationally in the same cycle.
REQ-008 data_address  output  32  byte address for load/store.
REQ-009 data_write  output  1  store strobe; memory writes on the next rising edge.
REQ-010 data_read  output  1  load strobe.
REQ-011 data_writedata  output  32  store data.
REQ-012 data_readdata  input  32  load data, valid combinationally in the same cycle.
REQ-013 Port order for positional instantiation: clk, reset, active, register_v0, clk_enable, instr_address, instr_readdata, data_address, data_write, data_read, data_writedata, data_readdata.

Function
REQ-014 Single-cycle, non-pipelined, no branch delay slot: each instruction is fetched, executed and retired in one clock; PC and register file update on the rising edge.
REQ-015 32x32 register file; $0 reads as 0 and ignores writes; two combinational read ports, one synchronous write port.
REQ-016 Supported: ADDU, SUBU, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, JR, ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI, LW, SW, BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, BLTZAL, BGEZAL, J, JAL.
REQ-017 Arithmetic wraps modulo 2^32, no overflow traps; ADDIU/SLTI/SLTIU/load/store sign-extend imm; ANDI/ORI/XORI zero-extend; LUI loads imm<<16.
REQ-018 LW: data_address = rs + sext(imm), data_read=1, rt <= data_readdata at clock edge.
REQ-019 SW: data_address = rs + sext(imm), data_writedata = rt, data_write=1; data_read=data_write=0 for all other instructions.
REQ-020 Conditional branch target = address of branch instruction + sext(imm16) (byte offset, unshifted); not taken -> PC+4.
REQ-021 REGIMM (opcode 000001) decoded by rt: 00000 BLTZ, 00001 BGEZ, 10000 BLTZAL, 10001 BGEZAL; comparison treats rs as signed.
REQ-022 BLTZAL/BGEZAL write $31 <= branch address + 8 whether or not taken; JAL writes $31 <= PC + 8.
REQ-023 J/JAL target = {PC[31:28], instr[25:0], 2'b00}; JR target = rs.
REQ-024 Halt: a jump (J, JAL or JR) whose target is 0x00000000 drives active low from the next cycle; PC, registers and memory strobes then freeze (data_read=data_write=0) until reset.
REQ-025 Undefined opcodes execute as NOP (PC+4, no writes).

Reset
REQ-026 While reset=1 at a rising edge: PC <= 0xBFC00000, all GPRs <= 0, active <= 1.
REQ-027 During and after reset, data_read=data_write=0 until an LW/SW is decoded; first instruction fetched from 0xBFC00000 in the cycle after reset deasserts.
REQ-028 Reset asserted mid-operation or while halted overrides all other activity, including a pending store.

Configuration
REQ-029 Macro MIPS_CLK_ENABLE_EN: when defined, PC, register file, active and data_write are updated/asserted only when clk_enable=1 (otherwise the state holds and data_write=0); reset still acts regardless of clk_enable.
REQ-030 Without MIPS_CLK_ENABLE_EN, clk_enable is ignored and the CPU advances every clock.

Verification
REQ-031 Reset then ADDIU $1,$0,0x20 -> instr_address=0xBFC00000 in first cycle, $1=0x20 afterwards.
REQ-032 LW $2,0($1) with data_readdata=0xF0000000 -> data_address=0x20, data_read=1, register_v0=0xF0000000 next cycle.
REQ-033 BLTZAL $2,0x0080 at 0xBFC00008 with $2 negative -> next instr_address=0xBFC00088, $31=0xBFC00010.
REQ-034 BLTZAL $1,0x0080 at 0xBFC0008C with $1=0x20 -> not taken, next instr_address=0xBFC00090, $31=0xBFC00094.
REQ-035 SW $1,4($0) with $1=0x20 -> data_address=4, data_writedata=0x20, data_write=1 for exactly one cycle.
REQ-036 JR $0 -> active=0 next cycle, instr_address and register_v0 stay constant for 3+ cycles; reset -> active=1, PC=0xBFC00000.

Source files
------------

// File: rtl/mips_cpu_harvard.sv
// Single-cycle MIPS-I subset CPU with separate instruction and data ports.
// Optional macro MIPS_CLK_ENABLE_EN: when defined, clk_enable qualifies every state update.
module mips_cpu_harvard (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  input  logic        clk_enable,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state, next_state;
  logic [31:0] pc;
  logic [31:0] regs [32];
  logic        step;

`ifdef MIPS_CLK_ENABLE_EN
  assign step = clk_enable;
`else
  logic unused_clk_enable;
  assign unused_clk_enable = clk_enable;
  assign step = 1'b1;
`endif

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] rs_val, rt_val, sext_imm, zext_imm;
  logic [31:0] pc_plus4, pc_plus8, branch_target, jump_target;

  assign opcode   = instr_readdata[31:26];
  assign rs       = instr_readdata[25:21];
  assign rt       = instr_readdata[20:16];
  assign rd       = instr_readdata[15:11];
  assign shamt    = instr_readdata[10:6];
  assign funct    = instr_readdata[5:0];
  assign imm      = instr_readdata[15:0];
  assign rs_val   = regs[rs];
  assign rt_val   = regs[rt];
  assign sext_imm = {{16{imm[15]}}, imm};
  assign zext_imm = {16'h0000, imm};

  assign pc_plus4      = pc + 32'd4;
  assign pc_plus8      = pc + 32'd8;
  assign branch_target = pc + sext_imm;
  assign jump_target   = {pc[31:28], instr_readdata[25:0], 2'b00};

  logic [31:0] next_pc, wr_data;
  logic [4:0]  wr_addr;
  logic        wr_en, is_load, is_store, is_jump, regimm_taken;

  assign regimm_taken = rt[0] ? ~rs_val[31] : rs_val[31];

  always_comb begin
    next_pc  = pc_plus4;
    wr_en    = 1'b0;
    wr_addr  = rt;
    wr_data  = 32'h0;
    is_load  = 1'b0;
    is_store = 1'b0;
    is_jump  = 1'b0;
    case (opcode)
      6'h00: begin
        wr_addr = rd;
        case (funct)
          6'h00: begin wr_en = 1'b1; wr_data = rt_val << shamt; end
          6'h02: begin wr_en = 1'b1; wr_data = rt_val >> shamt; end
          6'h03: begin wr_en = 1'b1; wr_data = $signed(rt_val) >>> shamt; end
          6'h08: begin next_pc = rs_val; is_jump = 1'b1; end
          6'h21: begin wr_en = 1'b1; wr_data = rs_val + rt_val; end
          6'h23: begin wr_en = 1'b1; wr_data = rs_val - rt_val; end
          6'h24: begin wr_en = 1'b1; wr_data = rs_val & rt_val; end
          6'h25: begin wr_en = 1'b1; wr_data = rs_val | rt_val; end
          6'h26: begin wr_en = 1'b1; wr_data = rs_val ^ rt_val; end
          6'h2A: begin wr_en = 1'b1; wr_data = {31'b0, $signed(rs_val) < $signed(rt_val)}; end
          6'h2B: begin wr_en = 1'b1; wr_data = {31'b0, rs_val < rt_val}; end
          default: ;
        endcase
      end
      6'h01: begin
        // Only BLTZ/BGEZ/BLTZAL/BGEZAL; link happens whether or not taken.
        if (rt[3:1] == 3'b000) begin
          if (regimm_taken) next_pc = branch_target;
          if (rt[4]) begin
            wr_en   = 1'b1;
            wr_addr = 5'd31;
            wr_data = pc_plus8;
          end
        end
      end
      6'h02: begin next_pc = jump_target; is_jump = 1'b1; end
      6'h03: begin
        next_pc = jump_target;
        is_jump = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 5'd31;
        wr_data = pc_plus8;
      end
      6'h04: if (rs_val == rt_val) next_pc = branch_target;
      6'h05: if (rs_val != rt_val) next_pc = branch_target;
      6'h06: if ($signed(rs_val) <= 0) next_pc = branch_target;
      6'h07: if ($signed(rs_val) > 0) next_pc = branch_target;
      6'h09: begin wr_en = 1'b1; wr_data = rs_val + sext_imm; end
      6'h0A: begin wr_en = 1'b1; wr_data = {31'b0, $signed(rs_val) < $signed(sext_imm)}; end
      6'h0B: begin wr_en = 1'b1; wr_data = {31'b0, rs_val < sext_imm}; end
      6'h0C: begin wr_en = 1'b1; wr_data = rs_val & zext_imm; end
      6'h0D: begin wr_en = 1'b1; wr_data = rs_val | zext_imm; end
      6'h0E: begin wr_en = 1'b1; wr_data = rs_val ^ zext_imm; end
      6'h0F: begin wr_en = 1'b1; wr_data = {imm, 16'h0000}; end
      6'h23: begin is_load = 1'b1; wr_en = 1'b1; wr_data = data_readdata; end
      6'h2B: is_store = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    next_state = state;
    if (state == RUN && step && is_jump && next_pc == 32'h0) next_state = HALTED;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= 32'hBFC0_0000;
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (state == RUN && step) begin
      pc <= next_pc;
      if (wr_en && wr_addr != 5'd0) regs[wr_addr] <= wr_data;
    end
  end

  // Strobes are masked while in reset or halted so no stray memory access leaks out.
  assign active         = (state == RUN);
  assign register_v0    = regs[2];
  assign instr_address  = pc;
  assign data_address   = rs_val + sext_imm;
  assign data_writedata = rt_val;
  assign data_read      = active && !reset && is_load;
  assign data_write     = active && !reset && is_store && step;

endmodule

// File: tb/tb_mips_cpu_harvard.sv
// [TB] Directed self-checking bench for mips_cpu_harvard with hand-encoded instructions.
module tb_mips_cpu_harvard;

  logic        clk = 1'b0;
  logic        reset;
  logic        active;
  logic [31:0] register_v0;
  logic        clk_enable;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  int total = 0;
  int bad   = 0;

  mips_cpu_harvard dut (
    .clk(clk),
    .reset(reset),
    .active(active),
    .register_v0(register_v0),
    .clk_enable(clk_enable),
    .instr_address(instr_address),
    .instr_readdata(instr_readdata),
    .data_address(data_address),
    .data_write(data_write),
    .data_read(data_read),
    .data_writedata(data_writedata),
    .data_readdata(data_readdata)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic applyStimulus(input logic rst, input logic [31:0] instr, input logic [31:0] rdata);
    @(negedge clk);
    reset          = rst;
    instr_readdata = instr;
    data_readdata  = rdata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  localparam logic [31:0] NOP         = 32'h0000_0000;
  localparam logic [31:0] ADDIU_1_20  = 32'h2401_0020;
  localparam logic [31:0] LW_2_0_1    = 32'h8C22_0000;
  localparam logic [31:0] BLTZAL_2    = 32'h0450_0080;
  localparam logic [31:0] BLTZAL_1    = 32'h0430_0080;
  localparam logic [31:0] ADDU_2_0_31 = 32'h001F_1021;
  localparam logic [31:0] SW_1_4_0    = 32'hAC01_0004;
  localparam logic [31:0] BEQ_BACK8   = 32'h1000_FFF8;
  localparam logic [31:0] LUI_2_1234  = 32'h3C02_1234;
  localparam logic [31:0] ORI_2_8001  = 32'h3442_8001;
  localparam logic [31:0] SUBU_2_0_2  = 32'h0002_1023;
  localparam logic [31:0] SRA_2_2_4   = 32'h0002_1103;
  localparam logic [31:0] SLT_2_2_1   = 32'h0041_102A;
  localparam logic [31:0] UNDEF_OP    = 32'hFC00_0000;
  localparam logic [31:0] BNE_2_0_10  = 32'h1440_0010;
  localparam logic [31:0] J_BFC00100  = 32'h0BF0_0040;
  localparam logic [31:0] JR_0        = 32'h0000_0008;
  localparam logic [31:0] ADDIU_2_5   = 32'h2402_0005;

  initial begin
    reset          = 1'b1;
    clk_enable     = 1'b1;
    instr_readdata = NOP;
    data_readdata  = 32'h0;

    applyStimulus(1'b1, SW_1_4_0, 32'h0);
    checkOutput("reset_no_write", {31'b0, data_write}, 32'd0);
    applyStimulus(1'b1, LW_2_0_1, 32'h0);
    checkOutput("reset_no_read", {31'b0, data_read}, 32'd0);

    applyStimulus(1'b0, ADDIU_1_20, 32'h0);
    checkOutput("reset_pc", instr_address, 32'hBFC0_0000);
    checkOutput("reset_active", {31'b0, active}, 32'd1);
    checkOutput("reset_v0", register_v0, 32'h0);
    checkOutput("addiu_no_read", {31'b0, data_read}, 32'd0);

    applyStimulus(1'b0, LW_2_0_1, 32'hF000_0000);
    checkOutput("lw_pc", instr_address, 32'hBFC0_0004);
    checkOutput("lw_addr", data_address, 32'h0000_0020);
    checkOutput("lw_read", {31'b0, data_read}, 32'd1);
    checkOutput("lw_no_write", {31'b0, data_write}, 32'd0);

    applyStimulus(1'b0, BLTZAL_2, 32'h0);
    checkOutput("lw_v0", register_v0, 32'hF000_0000);
    checkOutput("bltzal_pc", instr_address, 32'hBFC0_0008);
    checkOutput("bltzal_no_read", {31'b0, data_read}, 32'd0);

    applyStimulus(1'b0, ADDU_2_0_31, 32'h0);
    checkOutput("bltzal_taken_pc", instr_address, 32'hBFC0_0088);

    applyStimulus(1'b0, BLTZAL_1, 32'h0);
    checkOutput("bltzal_link", register_v0, 32'hBFC0_0010);
    checkOutput("bltzal1_pc", instr_address, 32'hBFC0_008C);

    applyStimulus(1'b0, ADDU_2_0_31, 32'h0);
    checkOutput("bltzal_not_taken_pc", instr_address, 32'hBFC0_0090);

    applyStimulus(1'b0, SW_1_4_0, 32'h0);
    checkOutput("bltzal_nt_link", register_v0, 32'hBFC0_0094);
    checkOutput("sw_pc", instr_address, 32'hBFC0_0094);
    checkOutput("sw_addr", data_address, 32'h0000_0004);
    checkOutput("sw_data", data_writedata, 32'h0000_0020);
    checkOutput("sw_write", {31'b0, data_write}, 32'd1);
    checkOutput("sw_no_read", {31'b0, data_read}, 32'd0);

    applyStimulus(1'b0, BEQ_BACK8, 32'h0);
    checkOutput("sw_one_cycle", {31'b0, data_write}, 32'd0);
    checkOutput("beq_pc", instr_address, 32'hBFC0_0098);

    applyStimulus(1'b0, LUI_2_1234, 32'h0);
    checkOutput("beq_taken_pc", instr_address, 32'hBFC0_0090);

    applyStimulus(1'b0, ORI_2_8001, 32'h0);
    checkOutput("lui_v0", register_v0, 32'h1234_0000);

    applyStimulus(1'b0, SUBU_2_0_2, 32'h0);
    checkOutput("ori_zext_v0", register_v0, 32'h1234_8001);

    applyStimulus(1'b0, SRA_2_2_4, 32'h0);
    checkOutput("subu_v0", register_v0, 32'hEDCB_7FFF);

    applyStimulus(1'b0, SLT_2_2_1, 32'h0);
    checkOutput("sra_v0", register_v0, 32'hFEDC_B7FF);

    applyStimulus(1'b0, UNDEF_OP, 32'h0);
    checkOutput("slt_v0", register_v0, 32'h0000_0001);
    checkOutput("undef_pc", instr_address, 32'hBFC0_00A4);
    checkOutput("undef_no_write", {31'b0, data_write}, 32'd0);

    applyStimulus(1'b0, BNE_2_0_10, 32'h0);
    checkOutput("undef_v0_kept", register_v0, 32'h0000_0001);
    checkOutput("bne_pc", instr_address, 32'hBFC0_00A8);

    applyStimulus(1'b0, J_BFC00100, 32'h0);
    checkOutput("bne_taken_pc", instr_address, 32'hBFC0_00B8);

    applyStimulus(1'b0, JR_0, 32'h0);
    checkOutput("j_target_pc", instr_address, 32'hBFC0_0100);
    checkOutput("jr_active_before", {31'b0, active}, 32'd1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, (i == 1) ? SW_1_4_0 : ADDIU_2_5, 32'h0);
      checkOutput("halt_active", {31'b0, active}, 32'd0);
      checkOutput("halt_pc", instr_address, 32'h0000_0000);
      checkOutput("halt_v0", register_v0, 32'h0000_0001);
      checkOutput("halt_no_write", {31'b0, data_write}, 32'd0);
    end
    applyStimulus(1'b0, LW_2_0_1, 32'h1234_5678);
    checkOutput("halt_no_read", {31'b0, data_read}, 32'd0);
    checkOutput("halt_v0_after_lw", register_v0, 32'h0000_0001);

    applyStimulus(1'b1, SW_1_4_0, 32'h0);
    checkOutput("rereset_no_write", {31'b0, data_write}, 32'd0);

    applyStimulus(1'b0, NOP, 32'h0);
    checkOutput("rereset_active", {31'b0, active}, 32'd1);
    checkOutput("rereset_pc", instr_address, 32'hBFC0_0000);
    checkOutput("rereset_v0", register_v0, 32'h0);

    applyStimulus(1'b0, NOP, 32'h0);
    checkOutput("rerun_pc", instr_address, 32'hBFC0_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
